// File: rtl/adc_sample_sched.sv
// Round-robin scheduler sharing one serial 8-bit ADC core between N_REQ requesters.
// Optional two-conversion-per-grant (dummy read) mode: define ADC_SCHED_DUMMY_READ_EN.
module adc_sample_sched #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned HOLDOFF_CYC = 1000,
    parameter int unsigned TIMEOUT_CYC = 4095,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_id,
    output logic [7:0]       rsp_data,
    output logic             rsp_err,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [7:0]       adc_data,
    output logic             busy,
    output logic [CNT_W-1:0] conv_count
);

    localparam int unsigned HO_W = (HOLDOFF_CYC < 1) ? 1 : $clog2(HOLDOFF_CYC + 1);
    localparam int unsigned TO_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

`ifdef ADC_SCHED_DUMMY_READ_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_HOLD, S_DELIVER} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DELIVER} state_t;
`endif

    state_t           state, state_nx;
    logic [ID_W-1:0]  ptr, ptr_nx;
    logic [HO_W-1:0]  holdoff, holdoff_nx;
    logic [TO_W-1:0]  tmo, tmo_nx;
    logic [N_REQ-1:0] grant_nx;
    logic             rsp_valid_nx;
    logic [ID_W-1:0]  rsp_id_nx;
    logic [7:0]       rsp_data_nx;
    logic             rsp_err_nx;
    logic             adc_start_nx;
    logic             busy_nx;
    logic [CNT_W-1:0] conv_count_nx;
    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  cand;
`ifdef ADC_SCHED_DUMMY_READ_EN
    logic             phase, phase_nx;
`endif

    // First requesting index at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ID_W'((32'(ptr) + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        ptr_nx        = ptr;
        holdoff_nx    = (holdoff != '0) ? holdoff - HO_W'(1) : '0;
        tmo_nx        = tmo;
        grant_nx      = grant;
        rsp_valid_nx  = 1'b0;
        rsp_id_nx     = rsp_id;
        rsp_data_nx   = rsp_data;
        rsp_err_nx    = rsp_err;
        adc_start_nx  = 1'b0;
        conv_count_nx = conv_count;
`ifdef ADC_SCHED_DUMMY_READ_EN
        phase_nx      = phase;
`endif
        case (state)
            S_IDLE: begin
                if (enable && holdoff == '0 && win_found) begin
                    state_nx     = S_START;
                    grant_nx     = N_REQ'(1) << win_idx;
                    rsp_id_nx    = win_idx;
                    adc_start_nx = 1'b1;
`ifdef ADC_SCHED_DUMMY_READ_EN
                    phase_nx     = 1'b0;
`endif
                end
            end
            S_START: begin
                tmo_nx   = TO_W'(TIMEOUT_CYC);
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // A done strobe on the expiry cycle still counts as success.
                if (adc_done) begin
`ifdef ADC_SCHED_DUMMY_READ_EN
                    if (!phase) begin
                        state_nx   = S_HOLD;
                        holdoff_nx = HO_W'(HOLDOFF_CYC);
                        phase_nx   = 1'b1;
                    end else begin
                        state_nx     = S_DELIVER;
                        rsp_valid_nx = 1'b1;
                        rsp_data_nx  = adc_data;
                        rsp_err_nx   = 1'b0;
                    end
`else
                    state_nx     = S_DELIVER;
                    rsp_valid_nx = 1'b1;
                    rsp_data_nx  = adc_data;
                    rsp_err_nx   = 1'b0;
`endif
                end else if (tmo <= TO_W'(1)) begin
                    state_nx     = S_DELIVER;
                    rsp_valid_nx = 1'b1;
                    rsp_data_nx  = 8'h00;
                    rsp_err_nx   = 1'b1;
                end else begin
                    tmo_nx = tmo - TO_W'(1);
                end
            end
`ifdef ADC_SCHED_DUMMY_READ_EN
            S_HOLD: begin
                if (holdoff <= HO_W'(1)) begin
                    state_nx     = S_START;
                    adc_start_nx = 1'b1;
                end
            end
`endif
            S_DELIVER: begin
                state_nx   = S_IDLE;
                grant_nx   = '0;
                holdoff_nx = HO_W'(HOLDOFF_CYC);
                ptr_nx     = (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
                if (!rsp_err) begin
                    conv_count_nx = conv_count + CNT_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            holdoff    <= '0;
            tmo        <= '0;
            grant      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            adc_start  <= 1'b0;
            busy       <= 1'b0;
            conv_count <= '0;
`ifdef ADC_SCHED_DUMMY_READ_EN
            phase      <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            holdoff    <= holdoff_nx;
            tmo        <= tmo_nx;
            grant      <= grant_nx;
            rsp_valid  <= rsp_valid_nx;
            rsp_id     <= rsp_id_nx;
            rsp_data   <= rsp_data_nx;
            rsp_err    <= rsp_err_nx;
            adc_start  <= adc_start_nx;
            busy       <= busy_nx;
            conv_count <= conv_count_nx;
`ifdef ADC_SCHED_DUMMY_READ_EN
            phase      <= phase_nx;
`endif
        end
    end

endmodule

// File: tb/tb_adc_sample_sched.sv
// Scoreboard bench for adc_sample_sched: behavioural ADC core, expected-response queue.
module tb_adc_sample_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned HO  = 30;
    localparam int unsigned TMO = 60;
    localparam int unsigned CW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          rsp_valid;
    logic [IW-1:0] rsp_id;
    logic [7:0]    rsp_data;
    logic          rsp_err;
    logic          adc_start;
    logic          adc_done;
    logic [7:0]    adc_data;
    logic          busy;
    logic [CW-1:0] conv_count;

    adc_sample_sched #(
        .N_REQ(N), .ID_W(IW), .HOLDOFF_CYC(HO), .TIMEOUT_CYC(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .grant(grant),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .busy(busy), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [7:0]    data;
        logic          err;
    } exp_t;

    typedef struct {
        int        delay;
        logic [7:0] data;
    } conv_t;

    exp_t  sb_q[$];
    conv_t adc_q[$];
    int    start_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    n_rsp = 0;
    int    n_start = 0;
    int    last_start = 0;
    int    last_rsp = 0;
    logic  prev_start = 1'b0;
    logic  prev_valid = 1'b0;
    int    mptr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: one-cycle strobes and scoreboard pop on each response.
    always @(negedge clk) begin
        if (!reset) begin
            if (adc_start) begin
                n_start++;
                last_start = cyc;
                start_q.push_back(cyc);
                check("start_one_cycle", 32'(prev_start), 0);
            end
            if (rsp_valid) begin
                n_rsp++;
                last_rsp = cyc;
                check("valid_one_cycle", 32'(prev_valid), 0);
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("grant_at_rsp", 32'(grant), 32'(N'(1) << e.id));
                end
            end
            prev_start = adc_start;
            prev_valid = rsp_valid;
        end
    end

    // Behavioural ADC core: answers each adc_start from adc_q, stays silent if empty.
    initial begin
        adc_done = 1'b0;
        adc_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (adc_start && !reset && adc_q.size() != 0) begin
                conv_t c;
                c = adc_q.pop_front();
                repeat (c.delay) @(posedge clk);
                #1;
                adc_done = 1'b1;
                adc_data = c.data;
                @(posedge clk);
                #1;
                adc_done = 1'b0;
            end
        end
    end

    task automatic wait_rsp(input int target, input int budget);
        int b = budget;
        while (n_rsp < target && b > 0) begin
            @(posedge clk);
            b--;
        end
        #1;
        check("wait_rsp", 32'(n_rsp), 32'(target));
    endtask

    task automatic wait_start(input int target, input int budget);
        int b = budget;
        while (n_start < target && b > 0) begin
            @(posedge clk);
            b--;
        end
        #1;
        check("wait_start", 32'(n_start), 32'(target));
    endtask

    task automatic expect_rsp(input int id, input logic [7:0] data, input logic err);
        exp_t e;
        e.id   = IW'(id);
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    task automatic push_conv(input int delay, input logic [7:0] data);
        conv_t c;
        c.delay = delay;
        c.data  = data;
        adc_q.push_back(c);
    endtask

    initial begin
        int base;
        int nr;
        int ns;
        reset  = 1'b1;
        enable = 1'b1;
        req    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {grant, rsp_valid, rsp_id, rsp_data, rsp_err, adc_start, busy}, 0);
        check("rst_count", 32'(conv_count), 0);
        reset = 1'b0;

        // Single request, 20-cycle conversion.
        push_conv(20, 8'hA5);
        expect_rsp(1, 8'hA5, 1'b0);
        @(posedge clk); #1;
        req = 4'b0010;
        @(posedge clk); #1;
        check("t1_grant", 32'(grant), 32'h2);
        check("t1_start", 32'(adc_start), 1);
        wait_rsp(1, 200);
        check("t1_latency", 32'(last_rsp - last_start), 21);
        req = '0;
        repeat (2) @(posedge clk); #1;
        check("t1_count", 32'(conv_count), 1);
        check("t1_data_hold", 32'(rsp_data), 32'hA5);
        mptr = 2;

        // All requesting: round-robin order and holdoff spacing.
        base = start_q.size();
        nr = n_rsp;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_conv(3 + k, 8'(8'h10 + k));
            expect_rsp((mptr + k) % N, 8'(8'h10 + k), 1'b0);
        end
        wait_rsp(nr + 5, 5 * (HO + 60));
        req = '0;
        for (int k = 0; k < 4; k++) begin
            check("t2_gap", 32'(start_q[base + k + 1] - start_q[base + k]), 32'(3 + k + HO + 3));
            check("t2_gap_min", 32'(start_q[base + k + 1] - start_q[base + k] >= HO + 2), 1);
        end
        check("t2_count", 32'(conv_count), 6);
        mptr = (mptr + 5) % N;

        // Timeout: core never answers; request waits out holdoff first.
        nr = n_rsp;
        req = 4'b0001;
        expect_rsp(0, 8'h00, 1'b1);
        @(posedge clk); #1;
        check("t3_holdoff_wait", 32'(busy), 0);
        wait_rsp(nr + 1, HO + TMO + 50);
        check("t3_latency", 32'(last_rsp - last_start), TMO + 1);
        req = '0;
        repeat (2) @(posedge clk); #1;
        check("t3_count", 32'(conv_count), 6);
        mptr = 1;

        // Done coincident with timeout expiry wins.
        nr = n_rsp;
        push_conv(TMO, 8'h5C);
        expect_rsp(2, 8'h5C, 1'b0);
        req = 4'b0100;
        wait_rsp(nr + 1, HO + TMO + 50);
        check("t4_latency", 32'(last_rsp - last_start), TMO + 1);
        req = '0;
        repeat (2) @(posedge clk); #1;
        check("t4_count", 32'(conv_count), 7);
        mptr = 3;

        // Stray adc_done in IDLE is ignored.
        repeat (HO + 5) @(posedge clk); #1;
        nr = n_rsp;
        adc_done = 1'b1;
        adc_data = 8'hEE;
        @(posedge clk); #1;
        adc_done = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("stray_no_rsp", 32'(n_rsp), 32'(nr));
        check("stray_idle", 32'(busy), 0);
        check("stray_data_hold", 32'(rsp_data), 32'h5C);

        // Reset during WAIT: immediate clear, no response, pointer back to 0.
        ns = n_start;
        req = 4'b0010;
        wait_start(ns + 1, 50);
        repeat (5) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst_wait_outs", {grant, rsp_valid, rsp_id, rsp_data, rsp_err, adc_start, busy}, 0);
        check("rst_wait_count", 32'(conv_count), 0);
        repeat (2) @(posedge clk); #1;
        nr = n_rsp;
        push_conv(5, 8'h3C);
        expect_rsp(1, 8'h3C, 1'b0);
        req = 4'b1010;
        reset = 1'b0;
        @(posedge clk); #1;
        check("t5_grant_ptr0", 32'(grant), 32'h2);
        wait_rsp(nr + 1, 100);
        req = '0;
        repeat (2) @(posedge clk); #1;
        check("t5_count", 32'(conv_count), 1);

        // enable low blocks grants; dropping it mid-service lets the grant finish.
        enable = 1'b0;
        repeat (HO + 10) @(posedge clk); #1;
        ns = n_start;
        req = 4'b0001;
        repeat (10) @(posedge clk); #1;
        check("t6_disabled_idle", 32'(busy), 0);
        check("t6_disabled_nostart", 32'(n_start), 32'(ns));
        nr = n_rsp;
        push_conv(8, 8'h77);
        expect_rsp(0, 8'h77, 1'b0);
        enable = 1'b1;
        wait_start(ns + 1, 10);
        enable = 1'b0;
        wait_rsp(nr + 1, 100);
        repeat (HO + 20) @(posedge clk); #1;
        check("t6_no_regrant", 32'(n_start), 32'(ns + 1));
        check("t6_idle", 32'(busy), 0);
        check("t6_count", 32'(conv_count), 2);
        req = '0;
        enable = 1'b1;
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
